fetch_sequencer: RTL and testbench

- Instruction-fetch controller for the pipelined 9-bit CPU; owns the PC and drives the combinational instruction ROM (16-bit pc in, 9-bit {opcode[8:4], operand[3:0]} out).
- Registers each fetched word into the IF/ID pipeline register.
- Applies stalls and branch/jump redirects from later stages.
- Detects the halt opcode, drains the pipeline and then reports done.

---
 rtl/fetch_sequencer.sv | 118 +++++++++++
 tb/tb_fetch_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the instruction ROM and fills the IF/ID register.
// Latency 1 cycle ROM->IF/ID; stall holds PC and IF/ID, redirect flushes IF/ID and beats stall.
module fetch_sequencer #(
  parameter logic [15:0] START_PC     = 16'd1,
  parameter logic [4:0]  HALT_OP      = 5'b11010,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic [15:0] rom_pc,
  input  logic [8:0]  rom_instr,
  output logic [8:0]  if_instr,
  output logic [15:0] if_pc,
  output logic        if_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [8:0]  if_instr_q, if_instr_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= START_PC;
      if_instr_q    <= 9'h000;
      if_pc_q       <= 16'd0;
      if_valid_q    <= 1'b0;
      cnt_q         <= 4'd0;
      fetch_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_valid_q    <= if_valid_d;
      cnt_q         <= cnt_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_valid_d    = if_valid_q;
    cnt_d         = cnt_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if_valid_d = 1'b0;
        if (start) begin
          state_d       = S_FETCH;
          pc_d          = START_PC;
          fetch_count_d = 16'd0;
        end
      end
      S_FETCH: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_instr_d    = rom_instr;
          if_pc_d       = pc_q;
          if_valid_d    = 1'b1;
          fetch_count_d = fetch_count_q + 16'd1;
          // The halt word is kept in IF/ID; PC parks on it while the pipe drains.
          if (rom_instr[8:4] == HALT_OP) begin
            state_d = S_DRAIN;
            cnt_d   = 4'(DRAIN_CYCLES);
          end else begin
            pc_d = pc_q + 16'd1;
          end
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          state_d    = S_FETCH;
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_valid_d = 1'b0;
          if (cnt_q <= 4'd1) begin
            state_d = S_HALTED;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == S_FETCH) || (state_q == S_DRAIN);
    done        = (state_q == S_HALTED);
    rom_pc      = pc_q;
    if_instr    = if_instr_q;
    if_pc       = if_pc_q;
    if_valid    = if_valid_q;
    fetch_count = fetch_count_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small combinational ROM model.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] rom_pc;
  logic [8:0]  rom_instr;
  logic [8:0]  if_instr;
  logic [15:0] if_pc;
  logic        if_valid, busy, done;
  logic [15:0] fetch_count;

  logic [8:0] mem [0:63];
  localparam logic [8:0] HALT_WORD = {5'b11010, 4'h3};

  int errors = 0;
  int checks = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .rom_pc(rom_pc), .rom_instr(rom_instr), .if_instr(if_instr), .if_pc(if_pc),
    .if_valid(if_valid), .busy(busy), .done(done), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Out-of-range addresses return the halt word, except 16'hFFFF used for the wrap check.
  always_comb begin
    if (rom_pc < 16'd64)         rom_instr = mem[rom_pc[5:0]];
    else if (rom_pc == 16'hFFFF) rom_instr = 9'h005;
    else                         rom_instr = HALT_WORD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 9'(i);
    mem[6] = HALT_WORD;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = 16'd0;
    #12;
    chk("rst_rom_pc", rom_pc, 16'd1);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 16'd0);
    chk("rst_if_instr", if_instr, 9'h000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", fetch_count, 16'd0);
    rst_n = 1'b1;
    step(); step();

    // Run 1..6 with halt at 6, then drain.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_rom_pc", rom_pc, 16'd1);
    chk("start_if_valid", if_valid, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("seq_if_pc", if_pc, 32'(i));
      chk("seq_if_valid", if_valid, 1'b1);
      chk("seq_count", fetch_count, 32'(i));
      chk("seq_if_instr", if_instr, (i == 6) ? 32'(HALT_WORD) : 32'(i));
    end
    chk("halt_pc_hold", rom_pc, 16'd6);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("drain_busy", busy, 1'b1);
      chk("drain_done", done, 1'b0);
      chk("drain_if_valid", if_valid, 1'b0);
    end
    step();
    chk("halted_done", done, 1'b1);
    chk("halted_busy", busy, 1'b0);
    chk("halted_count", fetch_count, 16'd6);
    redirect_valid = 1'b1; redirect_target = 16'd9; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    chk("halted_ignores_redirect", rom_pc, 16'd6);
    chk("halted_stays", done, 1'b1);
    mem[6] = 9'd6;

    // Restart from HALTED, stall at pc=4.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_done", done, 1'b0);
    chk("restart_count", fetch_count, 16'd0);
    chk("restart_pc", rom_pc, 16'd1);
    step(); step(); step();
    chk("pre_stall_pc", rom_pc, 16'd4);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_rom_pc", rom_pc, 16'd4);
      chk("stall_if_pc", if_pc, 16'd3);
      chk("stall_count", fetch_count, 16'd3);
    end
    stall = 1'b0;
    step();
    chk("unstall_if_pc", if_pc, 16'd4);
    chk("unstall_count", fetch_count, 16'd4);
    start = 1'b1;
    for (int k = 6; k <= 10; k++) begin
      step();
      start = 1'b0;
      chk("adv_rom_pc", rom_pc, 32'(k));
    end

    // Redirect to 40 at pc=10.
    redirect_valid = 1'b1; redirect_target = 16'd40;
    step();
    redirect_valid = 1'b0;
    chk("redir_rom_pc", rom_pc, 16'd40);
    chk("redir_if_valid", if_valid, 1'b0);
    chk("redir_count", fetch_count, 16'd9);
    step();
    chk("redir_if_pc", if_pc, 16'd40);
    chk("redir_if_valid2", if_valid, 1'b1);
    chk("redir_count2", fetch_count, 16'd10);

    // Redirect and stall together.
    redirect_valid = 1'b1; redirect_target = 16'd50; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    chk("rs_rom_pc", rom_pc, 16'd50);
    chk("rs_if_valid", if_valid, 1'b0);
    step();
    chk("rs_if_pc", if_pc, 16'd50);

    // Out-of-range target fetches halt; redirect to 20 inside DRAIN.
    redirect_valid = 1'b1; redirect_target = 16'd100;
    step();
    redirect_valid = 1'b0;
    step();
    chk("oor_if_pc", if_pc, 16'd100);
    chk("oor_if_instr", if_instr, 32'(HALT_WORD));
    chk("oor_pc_hold", rom_pc, 16'd100);
    step(); step();
    redirect_valid = 1'b1; redirect_target = 16'd20;
    step();
    redirect_valid = 1'b0;
    chk("drain_redir_pc", rom_pc, 16'd20);
    chk("drain_redir_busy", busy, 1'b1);
    step();
    chk("drain_redir_if_pc", if_pc, 16'd20);
    chk("drain_redir_valid", if_valid, 1'b1);
    chk("drain_redir_done", done, 1'b0);

    // PC wrap at 16'hFFFF.
    redirect_valid = 1'b1; redirect_target = 16'hFFFF;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_if_pc", if_pc, 16'hFFFF);
    chk("wrap_rom_pc", rom_pc, 16'd0);
    step();
    chk("wrap_if_pc0", if_pc, 16'd0);
    chk("wrap_if_instr0", if_instr, 9'd0);

    // Asynchronous reset mid-fetch at pc=30.
    redirect_valid = 1'b1; redirect_target = 16'd30;
    step();
    redirect_valid = 1'b0;
    chk("pre_rst_pc", rom_pc, 16'd30);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_if_valid", if_valid, 1'b0);
    chk("arst_rom_pc", rom_pc, 16'd1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_count", fetch_count, 16'd0);
    #3 rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("refetch_if_pc", if_pc, 16'd1);
    chk("refetch_valid", if_valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
